// File: rtl/norm_exp_adjust.sv
// norm_exp_adjust: post-add/subtract normaliser for a floating-point datapath.
// Shifts the mantissa until the hidden bit is set, adjusting the exponent.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-low reset
//   start_i          request; accepted only while ready_o is high
//   Exp_i [EW-1:0]   biased exponent from the exponent path
//   Mant_i[SW-1:0]   unnormalised mantissa (bit SW-1 carry, bit SW-2 hidden)
//   ready_o          idle and able to accept start_i
//   done_o           one-cycle pulse, results valid
//   Exp_o, Mant_o    adjusted exponent / normalised mantissa (registered)
//   Overflow_flag_o, Underflow_flag_o, Zero_flag_o  result status
module norm_exp_adjust #(
    parameter int EW = 8,
    parameter int SW = 25
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [EW-1:0] Exp_i,
    input  logic [SW-1:0] Mant_i,
    output logic          ready_o,
    output logic          done_o,
    output logic [EW-1:0] Exp_o,
    output logic [SW-1:0] Mant_o,
    output logic          Overflow_flag_o,
    output logic          Underflow_flag_o,
    output logic          Zero_flag_o
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT_R,
        SHIFT_L,
        DONE
    } state_t;

    localparam logic [EW-1:0] EXP_MAX = '1;
    localparam logic [EW-1:0] EXP_TOP = EXP_MAX - EW'(1);

    state_t        state, state_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [SW-1:0] mant_q, mant_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          zf_q, zf_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            exp_q            <= '0;
            mant_q           <= '0;
            ovf_q            <= 1'b0;
            unf_q            <= 1'b0;
            zf_q             <= 1'b0;
            Exp_o            <= '0;
            Mant_o           <= '0;
            Overflow_flag_o  <= 1'b0;
            Underflow_flag_o <= 1'b0;
            Zero_flag_o      <= 1'b0;
        end else begin
            state  <= state_d;
            exp_q  <= exp_d;
            mant_q <= mant_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            zf_q   <= zf_d;
            // Result registers load on entry to DONE so they are valid
            // alongside done_o and hold until the next result.
            if (state_d == DONE) begin
                Exp_o            <= exp_d;
                Mant_o           <= mant_d;
                Overflow_flag_o  <= ovf_d;
                Underflow_flag_o <= unf_d;
                Zero_flag_o      <= zf_d;
            end
        end
    end

    always_comb begin
        state_d = state;
        exp_d   = exp_q;
        mant_d  = mant_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        zf_d    = zf_q;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    exp_d   = Exp_i;
                    mant_d  = Mant_i;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zf_d    = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mant_q == '0) begin
                    exp_d   = '0;
                    zf_d    = 1'b1;
                    state_d = DONE;
                end else if (mant_q[SW-1]) begin
                    state_d = SHIFT_R;
                end else if (mant_q[SW-2]) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT_L;
                end
            end
            SHIFT_R: begin
                // Bits shifted out are folded into bit 0 as a sticky bit.
                mant_d = {1'b0, mant_q[SW-1:2], mant_q[1] | mant_q[0]};
                // Saturate instead of wrapping if the exponent is already
                // at or one below all-ones.
                if (exp_q >= EXP_TOP) begin
                    exp_d = EXP_MAX;
                    ovf_d = 1'b1;
                end else begin
                    exp_d = exp_q + EW'(1);
                end
                state_d = DONE;
            end
            SHIFT_L: begin
                if (exp_q == '0) begin
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[SW-2:0], 1'b0};
                    exp_d  = exp_q - EW'(1);
                    // Nonzero mantissa reaches the hidden bit within SW-2
                    // shifts, which bounds the loop.
                    if (mant_q[SW-3]) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o = (state == IDLE);
    assign done_o  = (state == DONE);

endmodule

// File: tb/tb_norm_exp_adjust.sv
// Directed self-checking bench for norm_exp_adjust.
// Latency is counted from the edge that samples start_i.
module tb_norm_exp_adjust;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  Exp_i;
    logic [24:0] Mant_i;
    logic        ready_o;
    logic        done_o;
    logic [7:0]  Exp_o;
    logic [24:0] Mant_o;
    logic        Overflow_flag_o;
    logic        Underflow_flag_o;
    logic        Zero_flag_o;

    int n_cmp = 0;
    int n_err = 0;

    norm_exp_adjust #(.EW(8), .SW(25)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .Exp_i            (Exp_i),
        .Mant_i           (Mant_i),
        .ready_o          (ready_o),
        .done_o           (done_o),
        .Exp_o            (Exp_o),
        .Mant_o           (Mant_o),
        .Overflow_flag_o  (Overflow_flag_o),
        .Underflow_flag_o (Underflow_flag_o),
        .Zero_flag_o      (Zero_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Exp_o, Mant_o, ovf, unf, zf}
    function automatic logic [35:0] res();
        return {Exp_o, Mant_o, Overflow_flag_o,
                Underflow_flag_o, Zero_flag_o};
    endfunction

    // Presents one request; returns after the sampling edge T (+1 time unit).
    task automatic launch(input logic [7:0] e, input logic [24:0] m);
        @(negedge clk);
        if (!ready_o) @(negedge clk);
        if (!ready_o) @(negedge clk);
        start_i = 1'b1;
        Exp_i   = e;
        Mant_i  = m;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Latency N means done_o is sampled high at edge T+N; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ready_o, done_o, res()} !== {2'b10, 36'h0}) begin
            n_err++;
            $display("FAIL reset: rdy/done/res=%b %b %h want 1 0 0",
                     ready_o, done_o, res());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_case(input string name, input logic [7:0] e,
                            input logic [24:0] m, input int exp_lat,
                            input logic [35:0] exp_res);
        int lat;
        launch(e, m);
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: ready_o=%b want 0", name, ready_o);
        end
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (res() !== exp_res) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, res(), exp_res);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({done_o, ready_o, res()} !== {2'b01, exp_res}) begin
            n_err++;
            $display("FAIL %s hold: done=%b rdy=%b res=%h want 0 1 %h",
                     name, done_o, ready_o, res(), exp_res);
        end
    endtask

    task automatic test_normalized();
        run_case("normalized", 8'h80, 25'h0800000, 2,
                 {8'h80, 25'h0800000, 3'b000});
    endtask

    task automatic test_carry();
        run_case("carry", 8'h7F, 25'h1000001, 3,
                 {8'h80, 25'h0800001, 3'b000});
    endtask

    task automatic test_left_shift();
        run_case("lshift15", 8'h20, 25'h0000100, 17,
                 {8'h11, 25'h0800000, 3'b000});
        run_case("lshift1", 8'h10, 25'h0400000, 3,
                 {8'h0F, 25'h0800000, 3'b000});
        run_case("lshift_to_zero", 8'h01, 25'h0400000, 3,
                 {8'h00, 25'h0800000, 3'b000});
    endtask

    task automatic test_underflow();
        run_case("underflow", 8'h03, 25'h0000001, 6,
                 {8'h00, 25'h0000008, 3'b010});
        run_case("underflow0", 8'h00, 25'h0000003, 3,
                 {8'h00, 25'h0000003, 3'b010});
    endtask

    task automatic test_overflow();
        run_case("overflow", 8'hFE, 25'h1000000, 3,
                 {8'hFF, 25'h0800000, 3'b100});
        run_case("carry_sticky", 8'h10, 25'h1FFFFFE, 3,
                 {8'h11, 25'h0FFFFFF, 3'b000});
    endtask

    task automatic test_zero();
        run_case("zero", 8'h55, 25'h0000000, 2,
                 {8'h00, 25'h0000000, 3'b001});
    endtask

    task automatic test_start_ignored();
        int lat;
        int extra;
        lat = -1;
        launch(8'h20, 25'h0000100);
        for (int n = 1; n <= 60; n++) begin
            if (n >= 3 && n <= 5) begin
                start_i = 1'b1;
                Exp_i   = 8'h01;
                Mant_i  = 25'h0800000;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            if (n == 4) begin
                n_cmp++;
                if (ready_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL ign_ready: ready_o=%b want 0", ready_o);
                end
            end
            if (done_o) begin
                lat = n + 1;
                break;
            end
        end
        start_i = 1'b0;
        n_cmp++;
        if (lat !== 17) begin
            n_err++;
            $display("FAIL ign_latency: got %0d want 17", lat);
        end
        n_cmp++;
        if (res() !== {8'h11, 25'h0800000, 3'b000}) begin
            n_err++;
            $display("FAIL ign_result: got %h want %h", res(),
                     {8'h11, 25'h0800000, 3'b000});
        end
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_o) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ign_spurious: done pulses=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        launch(8'h20, 25'h0000100);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ready_o, done_o, res()} !== {2'b10, 36'h0}) begin
            n_err++;
            $display("FAIL abort_state: rdy/done/res=%b %b %h want 1 0 0",
                     ready_o, done_o, res());
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_o) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL abort_done: pulses=%0d want 0", pulses);
        end
        run_case("after_abort", 8'h7F, 25'h1000001, 3,
                 {8'h80, 25'h0800001, 3'b000});
    endtask

    task automatic test_back_to_back();
        run_case("b2b_a", 8'h03, 25'h0000001, 6,
                 {8'h00, 25'h0000008, 3'b010});
        run_case("b2b_b", 8'hFE, 25'h1000000, 3,
                 {8'hFF, 25'h0800000, 3'b100});
        run_case("b2b_c", 8'h40, 25'h0000000, 2,
                 {8'h00, 25'h0000000, 3'b001});
    endtask

    initial begin
        start_i = 1'b0;
        Exp_i   = '0;
        Mant_i  = '0;
        rst     = 1'b0;
        test_reset();
        test_normalized();
        test_carry();
        test_left_shift();
        test_underflow();
        test_overflow();
        test_zero();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/norm_exp_adjust.md
NORM_EXP_ADJUST -- requirements
Module: norm_exp_adjust

Interface
REQ-001 SHALL have parameter EW, default 8, exponent width.
REQ-002 SHALL have parameter SW, default 25, mantissa width; bit SW-1 is the carry position and bit SW-2 is the hidden-bit position.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start_i  input  1  request to normalize the presented operands.
REQ-006 SHALL have port Exp_i  input  EW  biased exponent from the exponent add/subtract path.
REQ-007 SHALL have port Mant_i  input  SW  unnormalized mantissa sum/difference.
REQ-008 SHALL have port ready_o  output  1  high when idle and able to accept start_i.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port Exp_o  output  EW  adjusted exponent.
REQ-011 SHALL have port Mant_o  output  SW  normalized mantissa.
REQ-012 SHALL have ports Overflow_flag_o, Underflow_flag_o, Zero_flag_o  output  1 each  result status.

Function
REQ-013 SHALL implement states IDLE, CHECK, SHIFT_R, SHIFT_L, DONE.
REQ-014 IDLE: ready_o=1; start_i=1 at an edge captures Exp_i/Mant_i into working registers, clears working flags, next state CHECK.
REQ-015 start_i SHALL be ignored in every state other than IDLE; ready_o=0 outside IDLE.
REQ-016 CHECK: mantissa==0 -> exponent forced 0, zero flag set, go DONE; else bit SW-1=1 -> SHIFT_R; else bit SW-2=1 -> DONE; else -> SHIFT_L.
REQ-017 SHIFT_R (one cycle): mantissa shifted right 1, new bit 0 = old bit 1 OR old bit 0 (sticky); exponent +1; go DONE.
REQ-018 SHIFT_R: if incremented exponent equals all-ones (2^EW-1), overflow flag set; exponent output all-ones.
REQ-019 SHIFT_L, per cycle: if exponent==0 -> underflow flag set, no shift, go DONE; else mantissa shifted left 1 (zero fill), exponent -1; if new bit SW-2=1 -> DONE, else remain.
REQ-020 SHIFT_L SHALL never exceed SW-2 shifts; exponent SHALL never wrap below 0.
REQ-021 DONE: done_o=1 for exactly that cycle; next state IDLE.
REQ-022 Exp_o, Mant_o and flags SHALL be registered, loaded on entry to DONE, held stable until the next DONE.
REQ-023 Latency from sampling edge T: already normalized or zero -> done_o in cycle T+2; carry -> T+3; k left shifts -> T+2+k; underflow after k shifts -> T+3+k.
REQ-024 At most one of Overflow/Underflow/Zero SHALL be set per result.

Reset
REQ-025 rst=0 at an edge SHALL force IDLE, ready_o=1, done_o=0, Exp_o=0, Mant_o=0, all flags 0, regardless of state.
REQ-026 Reset mid-operation SHALL abort the operation with no done_o pulse; first start after reset release SHALL be accepted normally.

Verification
REQ-027 Exp_i=0x80, Mant_i=0x0800000 -> done_o at T+2, Exp_o=0x80, Mant_o=0x0800000, flags 0.
REQ-028 Exp_i=0x7F, Mant_i=0x1000001 -> done_o at T+3, Exp_o=0x80, Mant_o=0x0800001, flags 0.
REQ-029 Exp_i=0x20, Mant_i=0x0000100 -> done_o at T+17, Exp_o=0x11, Mant_o=0x0800000, flags 0.
REQ-030 Exp_i=0x03, Mant_i=0x0000001 -> done_o at T+6, Exp_o=0x00, Mant_o=0x0000008, Underflow_flag_o=1.
REQ-031 Exp_i=0xFE, Mant_i=0x1000000 -> done_o at T+3, Exp_o=0xFF, Overflow_flag_o=1; Mant_i=0 (any Exp_i) -> done_o at T+2, Exp_o=0, Zero_flag_o=1.
REQ-032 start during SHIFT_L ignored; rst=0 asserted mid-SHIFT_L -> no done_o, outputs zero, ready_o=1 next cycle; subsequent start completes correctly.
